sync_filter: RTL and testbench

SYNC_FILTER -- requirements
Module: sync_filter

---
 rtl/sync_filter.sv | 103 ++++++++++
 tb/tb_sync_filter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_filter.sv
// sync_filter: per-channel multi-flop synchronizer followed by a persistence
// filter. A new level is accepted onto sync_out only after the synchronized
// value has differed from sync_out for FILTER_LEN consecutive cycles. Each
// accepted change raises a one-cycle rise or fall pulse on that channel.
module sync_filter #(
   parameter int unsigned      WIDTH      = 4,
   parameter int unsigned      STAGES     = 2,
   parameter int unsigned      FILTER_LEN = 3,
   parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   // Counter width: at least one bit, so that FILTER_LEN == 1 still has a legal vector.
   localparam int unsigned      CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

   // Synchronizer chain, stage 0 samples the asynchronous pins.
   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic [STAGES-1:0][WIDTH-1:0] sync_d;

   // Last synchronizer stage: the first value that is safe to use in logic.
   logic [WIDTH-1:0]             s_last;

   // Per-channel persistence counters.
   logic [WIDTH-1:0][CNT_W-1:0]  cnt_q;
   logic [WIDTH-1:0][CNT_W-1:0]  cnt_d;

   // Accepted levels and the change pulses that accompany them.
   logic [WIDTH-1:0]             out_q;
   logic [WIDTH-1:0]             out_d;
   logic [WIDTH-1:0]             rise_q;
   logic [WIDTH-1:0]             rise_d;
   logic [WIDTH-1:0]             fall_q;
   logic [WIDTH-1:0]             fall_d;
   logic                         changed_q;
   logic                         changed_d;

   assign s_last = sync_q[STAGES-1];

   // Shift each channel one stage deeper into the synchronizer.
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = async_in;
      for (int unsigned k = 1; k < STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   // Persistence filter: count cycles of disagreement and accept at the limit.
   always_comb begin
      out_d  = out_q;
      cnt_d  = cnt_q;
      rise_d = '0;
      fall_d = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (s_last[i] == out_q[i]) begin
            // Agreement (or a glitch that reverted) discards any partial count.
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            // Level has persisted long enough; accept it and pulse the edge.
            out_d[i]  = s_last[i];
            cnt_d[i]  = '0;
            rise_d[i] = s_last[i];
            fall_d[i] = ~s_last[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      changed_d = |(rise_d | fall_d);
   end

   // State registers; reset loads the configured idle level everywhere.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q    <= {STAGES{RST_VAL}};
         cnt_q     <= '0;
         out_q     <= RST_VAL;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         out_q     <= out_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
      end
   end

   assign sync_out = out_q;
   assign rise     = rise_q;
   assign fall     = fall_q;
   assign changed  = changed_q;

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter: default instance (2 stages, filter 3) and a
// variant instance (3 stages, filter 1, idle level 4'b1010).
module tb_sync_filter;

   logic       clk;
   logic       n_rst;
   logic [3:0] async_in;
   logic [3:0] sync_out;
   logic [3:0] rise;
   logic [3:0] fall;
   logic       changed;

   logic [3:0] var_in;
   logic [3:0] var_out;
   logic [3:0] var_rise;
   logic [3:0] var_fall;
   logic       var_changed;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] so;
      logic [3:0] r;
      logic [3:0] f;
      logic       ch;
   } vec_t;

   vec_t tbl[$];

   sync_filter #(
      .WIDTH(4), .STAGES(2), .FILTER_LEN(3), .RST_VAL(4'b0000)
   ) u_dut (
      .clk(clk), .n_rst(n_rst), .async_in(async_in),
      .sync_out(sync_out), .rise(rise), .fall(fall), .changed(changed)
   );

   sync_filter #(
      .WIDTH(4), .STAGES(3), .FILTER_LEN(1), .RST_VAL(4'b1010)
   ) u_var (
      .clk(clk), .n_rst(n_rst), .async_in(var_in),
      .sync_out(var_out), .rise(var_rise), .fall(var_fall), .changed(var_changed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_main(input string tag, input logic [3:0] so, input logic [3:0] r,
                           input logic [3:0] f, input logic ch);
      chk({tag, " sync_out"}, sync_out, so);
      chk({tag, " rise"}, rise, r);
      chk({tag, " fall"}, fall, f);
      chk({tag, " changed"}, {3'b000, changed}, {3'b000, ch});
   endtask

   task automatic chk_var(input string tag, input logic [3:0] so, input logic [3:0] r,
                          input logic ch);
      chk({tag, " var sync_out"}, var_out, so);
      chk({tag, " var rise"}, var_rise, r);
      chk({tag, " var fall"}, var_fall, 4'b0000);
      chk({tag, " var changed"}, {3'b000, var_changed}, {3'b000, ch});
   endtask

   task automatic add(input logic [3:0] a, input logic [3:0] so, input logic [3:0] r,
                      input logic [3:0] f, input logic ch);
      vec_t v;
      v.a = a; v.so = so; v.r = r; v.f = f; v.ch = ch;
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Safety net against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int rise_cnt;

      // Per-cycle vectors: inputs sampled at the next edge, outputs checked just after it.
      // Latency: change at edge 0 -> accepted at edge 4.
      add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
      add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      // Glitch on channel 1: two cycles high is rejected.
      add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      // Move to 1000: channel 0 falls and channel 3 rises together.
      add(4'b1000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      add(4'b1000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      add(4'b1000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      add(4'b1000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      add(4'b1000, 4'b1000, 4'b1000, 4'b0001, 1'b1);
      add(4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0);
      // From settled 1000, switch to 0100 in one cycle.
      add(4'b0100, 4'b1000, 4'b0000, 4'b0000, 1'b0);
      add(4'b0100, 4'b1000, 4'b0000, 4'b0000, 1'b0);
      add(4'b0100, 4'b1000, 4'b0000, 4'b0000, 1'b0);
      add(4'b0100, 4'b1000, 4'b0000, 4'b0000, 1'b0);
      add(4'b0100, 4'b0100, 4'b0100, 4'b1000, 1'b1);
      add(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      // Channel 1 high for exactly three cycles: accepted, then released.
      add(4'b0110, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      add(4'b0110, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      add(4'b0110, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      add(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      add(4'b0100, 4'b0110, 4'b0010, 4'b0000, 1'b1);
      add(4'b0100, 4'b0110, 4'b0000, 4'b0000, 1'b0);
      add(4'b0100, 4'b0110, 4'b0000, 4'b0000, 1'b0);
      add(4'b0100, 4'b0100, 4'b0000, 4'b0010, 1'b1);
      add(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0);

      clk      = 1'b0;
      n_rst    = 1'b1;
      async_in = 4'h0;
      var_in   = 4'b1010;

      // Asynchronous reset, checked before any clock edge.
      #1 n_rst = 1'b0;
      async_in = 4'hF;
      #1;
      chk_main("async reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      chk_var("async reset", 4'b1010, 4'b0000, 1'b0);

      // Reset held with inputs active and the clock running.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_main($sformatf("reset hold %0d", i), 4'b0000, 4'b0000, 4'b0000, 1'b0);
         chk_var($sformatf("reset hold %0d", i), 4'b1010, 4'b0000, 1'b0);
      end

      // Release with inputs at the idle level: no pulses.
      async_in = 4'h0;
      @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_main($sformatf("release %0d", i), 4'b0000, 4'b0000, 4'b0000, 1'b0);
         chk_var($sformatf("release %0d", i), 4'b1010, 4'b0000, 1'b0);
      end

      // Table-driven section.
      foreach (tbl[i]) begin
         async_in = tbl[i].a;
         tick();
         chk_main($sformatf("vec%0d", i), tbl[i].so, tbl[i].r, tbl[i].f, tbl[i].ch);
      end

      // Reset assertion while sync_out is nonzero must not produce a fall pulse.
      async_in = 4'h0;
      n_rst    = 1'b0;
      #1;
      chk_main("assert with level", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick();
      tick();
      @(negedge clk);
      n_rst = 1'b1;
      tick();
      tick();
      chk_main("idle after reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // Mid-count reset: channel 2 rises, reset pulsed after edge 2.
      async_in = 4'b0100;
      tick();
      tick();
      tick();
      chk_main("mid before reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      n_rst = 1'b0;
      #1;
      chk_main("mid in reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick();
      chk_main("mid in reset clk", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      @(negedge clk);
      n_rst = 1'b1;
      rise_cnt = 0;
      for (int k = 0; k < 7; k++) begin
         tick();
         if (rise[2]) rise_cnt++;
         chk_main($sformatf("mid post %0d", k), (k >= 4) ? 4'b0100 : 4'b0000,
                  (k == 4) ? 4'b0100 : 4'b0000, 4'b0000, (k == 4));
      end
      chk("mid rise count", 4'(rise_cnt), 4'd1);

      // Variant instance: 3 stages, no filtering, accepted at edge 3.
      var_in = 4'b1011;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_var($sformatf("var %0d", k), (k >= 3) ? 4'b1011 : 4'b1010,
                 (k == 3) ? 4'b0001 : 4'b0000, (k == 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
